sum_sequencer: RTL and testbench

- Control FSM for the keypad calculator.
- Takes decoded key events from the keypad reader and builds two BCD operands, entering digits from the right.
- Launches the BCD adder through a start/done handshake and captures its result.
- Selects which 16-bit BCD value goes to the 7-segment display.
- Replaces ad-hoc counter sequencing in the calculator top level.

---
 rtl/sum_sequencer.sv | 144 ++++++++++++++
 tb/tb_sum_sequencer.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/sum_sequencer.sv
// Keypad calculator control FSM: builds two BCD operands, launches the adder, picks the display value.
// Latency: one key per cycle, add_start one cycle after '='; no backpressure, keys not accepted by a state are dropped.
// Optional SUMSEQ_LEAD_BLANK_EN: leading zero nibbles of disp_bcd become 4'hF (blank).
module sum_sequencer #(
    parameter int DIGITS  = 3,
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        key_valid,
    input  logic [3:0]  key_code,
    input  logic        add_done,
    input  logic [15:0] add_result,
    output logic [15:0] num1,
    output logic [15:0] num2,
    output logic        add_start,
    output logic [15:0] disp_bcd,
    output logic        busy,
    output logic        err
);
    localparam int CW = $clog2(DIGITS + 1);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] DMAX = CW'(DIGITS);
    localparam logic [TW-1:0] TMAX = TW'(TIMEOUT);

    typedef enum logic [1:0] {S_A, S_B, S_ADD, S_SHOW} state_t;

    state_t         state;
    logic [15:0]    result;
    logic [CW-1:0]  count;
    logic [TW-1:0]  tcnt;
    logic           is_digit, is_plus, is_eq, is_clr;
    logic [15:0]    raw_disp;

    assign is_digit = key_valid && (key_code <= 4'h9);
    assign is_plus  = key_valid && (key_code == 4'hA);
    assign is_eq    = key_valid && (key_code == 4'hB);
    assign is_clr   = key_valid && (key_code == 4'hC);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_A;
            num1      <= 16'h0;
            num2      <= 16'h0;
            result    <= 16'h0;
            count     <= '0;
            tcnt      <= '0;
            add_start <= 1'b0;
            err       <= 1'b0;
        end else begin
            add_start <= 1'b0;
            if (is_clr) begin
                // Leaving S_ADD here also orphans any add_done still in flight.
                state  <= S_A;
                num1   <= 16'h0;
                num2   <= 16'h0;
                result <= 16'h0;
                count  <= '0;
                err    <= 1'b0;
            end else begin
                case (state)
                    S_A: begin
                        if (is_digit && count < DMAX) begin
                            num1  <= {num1[11:0], key_code};
                            count <= count + CW'(1);
                        end else if (is_plus) begin
                            state <= S_B;
                            count <= '0;
                        end
                    end
                    S_B: begin
                        if (is_digit && count < DMAX) begin
                            num2  <= {num2[11:0], key_code};
                            count <= count + CW'(1);
                        end else if (is_eq) begin
                            state     <= S_ADD;
                            add_start <= 1'b1;
                            tcnt      <= '0;
                        end
                    end
                    S_ADD: begin
                        if (add_done) begin
                            result <= add_result;
                            err    <= 1'b0;
                            state  <= S_SHOW;
                        end else if (tcnt == TMAX) begin
                            result <= 16'hEEEE;
                            err    <= 1'b1;
                            state  <= S_SHOW;
                        end else begin
                            tcnt <= tcnt + TW'(1);
                        end
                    end
                    S_SHOW: begin
                        if (is_digit) begin
                            num1  <= {12'h0, key_code};
                            num2  <= 16'h0;
                            count <= CW'(1);
                            err   <= 1'b0;
                            state <= S_A;
                        end else if (is_plus && !err && result[15:12] == 4'h0) begin
                            // Chain only when the sum still fits as an operand slot.
                            num1  <= result;
                            num2  <= 16'h0;
                            count <= '0;
                            state <= S_B;
                        end
                    end
                    default: state <= S_A;
                endcase
            end
        end
    end

    assign busy = (state == S_ADD);

    always_comb begin
        raw_disp = num1;
        case (state)
            S_A:     raw_disp = num1;
            S_B:     raw_disp = num2;
            S_ADD:   raw_disp = num2;
            S_SHOW:  raw_disp = result;
            default: raw_disp = num1;
        endcase
    end

`ifdef SUMSEQ_LEAD_BLANK_EN
    always_comb begin
        logic lead;
        disp_bcd = raw_disp;
        lead     = (raw_disp != 16'hEEEE);
        for (int i = 3; i >= 1; i--) begin
            if (lead && raw_disp[i*4 +: 4] == 4'h0)
                disp_bcd[i*4 +: 4] = 4'hF;
            else
                lead = 1'b0;
        end
    end
`else
    assign disp_bcd = raw_disp;
`endif

endmodule

// File: tb/tb_sum_sequencer.sv
// Directed bench for sum_sequencer with a hand-driven adder.
module tb_sum_sequencer;
    logic        clk = 1'b0;
    logic        rst;
    logic        key_valid;
    logic [3:0]  key_code;
    logic        add_done;
    logic [15:0] add_result;
    logic [15:0] num1, num2, disp_bcd;
    logic        add_start, busy, err;

    int ncmp = 0;
    int nfail = 0;
    int start_cnt = 0;

    localparam logic [3:0] K_PLUS = 4'hA;
    localparam logic [3:0] K_EQ   = 4'hB;
    localparam logic [3:0] K_CLR  = 4'hC;

    sum_sequencer dut (
        .clk(clk), .rst(rst), .key_valid(key_valid), .key_code(key_code),
        .add_done(add_done), .add_result(add_result), .num1(num1), .num2(num2),
        .add_start(add_start), .disp_bcd(disp_bcd), .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (add_start === 1'b1) start_cnt <= start_cnt + 1;

    function automatic logic [15:0] ed(input logic [15:0] v);
`ifdef SUMSEQ_LEAD_BLANK_EN
        if (v == 16'hEEEE) return v;
        if (v[15:4] == 12'h0) return {12'hFFF, v[3:0]};
        if (v[15:8] == 8'h0) return {8'hFF, v[7:0]};
        if (v[15:12] == 4'h0) return {4'hF, v[11:0]};
        return v;
`else
        return v;
`endif
    endfunction

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic press(input logic [3:0] k);
        @(negedge clk);
        key_valid = 1'b1;
        key_code  = k;
        @(negedge clk);
        key_valid = 1'b0;
    endtask

    // Call right after press(K_EQ): done arrives three cycles after the start pulse.
    task automatic adder(input logic [15:0] val);
        check("start_pulse", add_start, 1'b1);
        check("busy_in_add", busy, 1'b1);
        @(negedge clk);
        check("start_once", add_start, 1'b0);
        repeat (2) @(negedge clk);
        add_done   = 1'b1;
        add_result = val;
        @(negedge clk);
        add_done   = 1'b0;
    endtask

    initial begin
        rst = 1'b1; key_valid = 1'b1; key_code = 4'h7; add_done = 1'b0; add_result = 16'h0;
        repeat (2) @(negedge clk);
        rst = 1'b0; key_valid = 1'b0;
        check("rst_num1", num1, 16'h0000);
        check("rst_num2", num2, 16'h0000);
        check("rst_disp", disp_bcd, ed(16'h0000));
        check("rst_start", add_start, 1'b0);
        check("rst_err", err, 1'b0);
        check("rst_busy", busy, 1'b0);

        // 12 + 34, operand B keys back-to-back
        press(4'h1); press(4'h2);
        press(K_EQ);
        check("eq_in_A_ignored", busy, 1'b0);
        press(K_PLUS);
        @(negedge clk); key_valid = 1'b1; key_code = 4'h3;
        @(negedge clk); key_code = 4'h4;
        @(negedge clk); key_valid = 1'b0;
        check("t1_num1", num1, 16'h0012);
        check("t1_num2", num2, 16'h0034);
        check("t1_disp_B", disp_bcd, ed(16'h0034));
        press(K_EQ);
        adder(16'h0046);
        check("t1_disp", disp_bcd, ed(16'h0046));
        check("t1_err", err, 1'b0);
        check("t1_busy", busy, 1'b0);
        check("t1_starts", 16'(start_cnt), 16'd1);

        // digit limit and 4-digit result
        press(K_CLR);
        check("clr_num1", num1, 16'h0000);
        check("clr_disp", disp_bcd, ed(16'h0000));
        press(4'h9); press(4'h8); press(4'h7); press(4'h6);
        check("t2_num1", num1, 16'h0987);
        press(K_PLUS); press(4'h9); press(4'h9); press(4'h9);
        check("t2_num2", num2, 16'h0999);
        press(K_EQ);
        adder(16'h1986);
        check("t2_disp", disp_bcd, ed(16'h1986));
        press(K_PLUS);
        check("t2_chain_blocked_disp", disp_bcd, ed(16'h1986));
        check("t2_chain_blocked_num1", num1, 16'h0987);

        // timeout
        press(4'h1);
        check("t3_newcalc_num1", num1, 16'h0001);
        press(K_PLUS); press(4'h2); press(K_EQ);
        repeat (250) @(negedge clk);
        check("t3_still_busy", busy, 1'b1);
        for (int i = 0; i < 30 && busy === 1'b1; i++) @(negedge clk);
        check("t3_timeout_left_add", busy, 1'b0);
        check("t3_err", err, 1'b1);
        check("t3_disp", disp_bcd, 16'hEEEE);
        press(K_PLUS);
        check("t3_plus_ignored_disp", disp_bcd, 16'hEEEE);
        check("t3_plus_ignored_err", err, 1'b1);
        press(4'h5);
        check("t3_num1", num1, 16'h0005);
        check("t3_err_clr", err, 1'b0);
        check("t3_disp5", disp_bcd, ed(16'h0005));

        // chaining, with a key dropped during S_ADD
        press(K_CLR);
        press(4'h1); press(4'h2); press(K_PLUS); press(4'h3); press(4'h4); press(K_EQ);
        adder(16'h0046);
        check("t4_first", disp_bcd, ed(16'h0046));
        press(K_PLUS);
        check("t4_num1", num1, 16'h0046);
        check("t4_num2_zero", num2, 16'h0000);
        press(4'h4); press(K_EQ);
        press(4'h7);
        check("t4_key_dropped", num2, 16'h0004);
        add_done = 1'b1; add_result = 16'h0050;
        @(negedge clk);
        add_done = 1'b0;
        check("t4_num1_held", num1, 16'h0046);
        check("t4_num2_held", num2, 16'h0004);
        check("t4_disp", disp_bcd, ed(16'h0050));

        // clear during S_ADD, then a late done
        press(4'h1); press(K_PLUS); press(4'h2); press(K_EQ);
        check("t5_busy", busy, 1'b1);
        press(K_CLR);
        add_done = 1'b1; add_result = 16'h0003;
        @(negedge clk);
        add_done = 1'b0;
        @(negedge clk);
        check("t5_busy_off", busy, 1'b0);
        check("t5_num1", num1, 16'h0000);
        check("t5_num2", num2, 16'h0000);
        check("t5_disp", disp_bcd, ed(16'h0000));
        check("t5_err", err, 1'b0);
        press(K_PLUS);
        check("t5_result_not_captured", disp_bcd, ed(16'h0000));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end
endmodule
